sa_dac_load: RTL and testbench
==============================

# sa_dac_load

Serial loader for the board's shift-register DAC ladder: the write-only counterpart of the successive-approximation ADC controller, which drives the same ser/sclk/lclk chain. It accepts one DATA_W-bit code per valid/ready handshake and shifts it MSB-first into the SR_W-bit external shift-register chain. It then pulses the latch clock so the ladder output updates atomically. It sits beside the ADC controller under the top level on the PLL clock and turns the ladder into a standalone DAC output, used for waveform generation and ADC loopback tests.

## Interface
- DATA_W, 14, code width; must be at most SR_W
- SR_W, 16, external shift-chain length in bits; upper SR_W-DATA_W bits are shifted as 0
- CLK_DIV, 2, clk_i cycles per sclk half-period; must be at least 1
- clk_i  in  1  system clock (PLL output)
- reset_ni  in  1  reset; asynchronous and active-low
- data_i  in  DATA_W  code to load, sampled on the accepting edge only
- valid_i  in  1  data_i valid
- ready_o  out  1  high exactly while in IDLE; combinational from state
- busy_o  out  1  high in every non-IDLE state
- done_o  out  1  one-cycle pulse after the latch completes
- ser_o  out  1  serial data to the chain
- sclk_o  out  1  shift clock; the chain samples on the rising edge
- lclk_o  out  1  latch clock; the ladder updates on the rising edge

## Operation
- States: IDLE, SETUP (sclk low), SHIFT (sclk high), LATCH (lclk high).
- IDLE:
  - ready_o=1.
  - When valid_i && ready_o on an edge, load the frame register with {zeros, data_i}, set the bit counter to SR_W-1, and go to SETUP.
- SETUP:
  - ser_o = frame[SR_W-1] and sclk_o=0 for CLK_DIV cycles, then go to SHIFT.
- SHIFT:
  - sclk_o=1 for CLK_DIV cycles.
  - On exit, shift the frame left by one.
  - If the counter is 0, go to LATCH; otherwise decrement the counter and go to SETUP.
- LATCH:
  - sclk_o=0 and lclk_o=1 for CLK_DIV cycles, then go to IDLE.
  - done_o=1 on the first IDLE cycle.
- ser_o changes only on SETUP entry, never while sclk_o=1. This gives CLK_DIV cycles of setup and hold around every rising sclk edge.
- lclk_o never overlaps sclk_o=1.
- valid_i and data_i are ignored while busy_o=1. data_i changes after acceptance have no effect.
- All outputs are registered except ready_o.
- Reset values: ser_o, sclk_o, lclk_o, done_o and busy_o are 0, ready_o is 1, and state is IDLE.
- Reset mid-frame: all outputs go low immediately (asynchronous) and lclk_o is never pulsed. The ladder keeps its previously latched code; only the partly shifted chain contents are lost.
- A half-period tick counter (0..CLK_DIV-1) restarts on every state entry.

## Timing
- E0 is the accepting edge. From E0, each bit takes 2·CLK_DIV cycles.
- The k-th rising edge of sclk_o (k=1..SR_W) occurs at E0 + (2k-1)·CLK_DIV.
- lclk_o rises at E0 + 2·SR_W·CLK_DIV and stays high for CLK_DIV cycles.
- done_o and ready_o are high at E0 + (2·SR_W+1)·CLK_DIV; with the defaults this is E0+66.
- Back-to-back: a new word can be accepted on the done_o cycle, so the frame period is (2·SR_W+1)·CLK_DIV+1 cycles.
- Throughput with the defaults at 36 MHz: 9 MHz sclk, about 537 k updates/s.

## Structure
- Package sa_dac_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, LATCH);
  - the default constants DATA_W=14 and SR_W=16;
  - the bit-counter width, $clog2(SR_W).
- The ADC controller shares SR_W and the chain-ordering constants from this package.
- One natural sub-module: sa_tick_div, a half-period counter with a restart input and a one-cycle tick output at CLK_DIV.

## Test plan
- Reset: hold reset_ni=0 -> ser_o, sclk_o, lclk_o, done_o and busy_o are 0 and ready_o=1; release -> no sclk activity with valid_i=0.
- Single load, data_i=14'h2AAA, CLK_DIV=2:
  - 16 sclk rising edges at E0+2, +6, … +62;
  - the bench's chain model captures 16'h2AAA MSB-first;
  - lclk_o is high over E0+64..65, and done_o pulses at E0+66.
- Back-to-back: valid_i held high with 14'h0000 then 14'h3FFF -> the second word is accepted at E0+66; the ladder model reads 0x0000, then 0x3FFF after the second done_o.
- Busy ignore: change data_i and toggle valid_i during the frame -> the latched value is the original word and only one done_o pulse occurs.
- Reset mid-frame: assert reset_ni after the 5th sclk edge -> outputs drop within the cycle, no lclk_o pulse, and the ladder keeps the prior code; the next load completes normally.
- CLK_DIV=1, data_i=14'h0001: last sclk rising edge at E0+31, lclk_o high at E0+32, done_o at E0+33, and the ladder reads 0x0001.

Source files
------------

// File: rtl/sa_dac_pkg.sv
// Shared definitions for the shift-register DAC ladder loader and its ADC sibling.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sa_dac_pkg;

  // Loader sequencer states: SETUP drives sclk low, SHIFT drives it high,
  // LATCH pulses lclk with sclk held low.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } sa_state_e;

  // Default code width and external chain length.
  localparam int unsigned SA_DATA_W = 14;
  localparam int unsigned SA_SR_W   = 16;

  // Bits are presented to the chain MSB first; the ADC controller walks the
  // same chain in the same order.
  localparam bit SA_MSB_FIRST = 1'b1;

  // Bit-counter width for the default chain.
  localparam int unsigned SA_CNT_W = $clog2(SA_SR_W);

  // Bit-counter width for an arbitrary chain length; never returns 0 so a
  // one-bit chain still gets a legal counter vector.
  function automatic int unsigned sa_cnt_w(input int unsigned sr_w);
    return (sr_w > 1) ? $clog2(sr_w) : 1;
  endfunction

endpackage

// File: rtl/sa_tick_div.sv
// Half-period tick generator: counts 0..CLK_DIV-1 and flags the last count.
// Latency: tick_o is combinational from the count; restart_i takes effect next cycle.
// Backpressure: none; free-running unless restarted.
module sa_tick_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic restart_i,
  output logic tick_o
);

  // Wide enough to hold CLK_DIV-1 even when CLK_DIV is 1.
  localparam int unsigned CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == CW'(CLK_DIV - 1));

  // Next count: restart forces zero, the terminal count wraps to zero.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sa_dac_load.sv
// Serial loader: shifts one DATA_W code MSB-first into an SR_W-bit chain, then pulses lclk.
// Latency: done_o at (2*SR_W+1)*CLK_DIV cycles after the accepting edge.
// Backpressure: ready_o is high only in IDLE; inputs are ignored while busy.
module sa_dac_load
  import sa_dac_pkg::*;
#(
  parameter int unsigned DATA_W  = SA_DATA_W,
  parameter int unsigned SR_W    = SA_SR_W,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              ser_o,
  output logic              sclk_o,
  output logic              lclk_o
);

  localparam int unsigned CNT_W = sa_cnt_w(SR_W);

  sa_state_e         state_q, state_d;
  logic [SR_W-1:0]   frame_q, frame_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              ser_q, ser_d;
  logic              sclk_q, sclk_d;
  logic              lclk_q, lclk_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              tick;
  logic              restart;

  // Every state change restarts the half-period count, so each state lasts
  // exactly CLK_DIV cycles regardless of where the counter was.
  assign restart = (state_d != state_q);

  sa_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // The only combinational output: accept exactly while idle.
  assign ready_o = (state_q == ST_IDLE);

  assign ser_o  = ser_q;
  assign sclk_o = sclk_q;
  assign lclk_o = lclk_q;
  assign done_o = done_q;
  assign busy_o = busy_q;

  // Sequencer next state, frame shifting and bit counting.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_i && ready_o) begin
          frame_d   = SR_W'(data_i);
          bit_cnt_d = CNT_W'(SR_W - 1);
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          frame_d = frame_q << 1;
          if (bit_cnt_q == '0) begin
            state_d = ST_LATCH;
          end else begin
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
            state_d   = ST_SETUP;
          end
        end
      end
      ST_LATCH: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered pin values derived from the state being entered. ser only
  // moves on SETUP entry, which keeps it stable for the whole sclk-high
  // phase and the CLK_DIV cycles before it.
  always_comb begin
    ser_d = ser_q;
    if ((state_d == ST_SETUP) && (state_q != ST_SETUP)) begin
      ser_d = frame_d[SR_W-1];
    end
    sclk_d = (state_d == ST_SHIFT);
    lclk_d = (state_d == ST_LATCH);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_LATCH) && (state_d == ST_IDLE);
  end

  // State and datapath registers; reset drops every pin low at once so an
  // interrupted frame never reaches the latch clock.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      ser_q     <= 1'b0;
      sclk_q    <= 1'b0;
      lclk_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      ser_q     <= ser_d;
      sclk_q    <= sclk_d;
      lclk_q    <= lclk_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_sa_dac_load.sv
// Bench for sa_dac_load: chain/ladder models watch the serial pins of two instances.
// Instance A uses CLK_DIV=2, instance B uses CLK_DIV=1.
// Inputs change and outputs are read 1 time unit after the falling clock edge.
module tb_sa_dac_load;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_ni = 1'b0;

  logic [13:0] data_a  = '0;
  logic        valid_a = 1'b0;
  logic        ready_a, busy_a, done_a, ser_a, sclk_a, lclk_a;

  logic [13:0] data_b  = '0;
  logic        valid_b = 1'b0;
  logic        ready_b, busy_b, done_b, ser_b, sclk_b, lclk_b;

  sa_dac_load #(.DATA_W(14), .SR_W(16), .CLK_DIV(2)) dut_a (
    .clk_i    (clk),
    .reset_ni (reset_ni),
    .data_i   (data_a),
    .valid_i  (valid_a),
    .ready_o  (ready_a),
    .busy_o   (busy_a),
    .done_o   (done_a),
    .ser_o    (ser_a),
    .sclk_o   (sclk_a),
    .lclk_o   (lclk_a)
  );

  sa_dac_load #(.DATA_W(14), .SR_W(16), .CLK_DIV(1)) dut_b (
    .clk_i    (clk),
    .reset_ni (reset_ni),
    .data_i   (data_b),
    .valid_i  (valid_b),
    .ready_o  (ready_b),
    .busy_o   (busy_b),
    .done_o   (done_b),
    .ser_o    (ser_b),
    .sclk_o   (sclk_b),
    .lclk_o   (lclk_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Chain / ladder model for instance A.
  logic        prev_sclk_a = 1'b0, prev_lclk_a = 1'b0, prev_ser_a = 1'b0;
  logic [15:0] chain_a = '0, ladder_a = '0;
  int          rise_a[$];
  int          lclk_cnt_a = 0, lclk_hi_a = 0, lclk_rise_a = -1, done_cnt_a = 0, viol_a = 0;

  always @(negedge clk) begin
    if (sclk_a && !prev_sclk_a) begin
      rise_a.push_back(cyc);
      chain_a <= {chain_a[14:0], ser_a};
    end
    if (lclk_a && !prev_lclk_a) begin
      ladder_a    <= chain_a;
      lclk_cnt_a  <= lclk_cnt_a + 1;
      lclk_rise_a <= cyc;
    end
    if (lclk_a) lclk_hi_a <= lclk_hi_a + 1;
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if ((prev_sclk_a && sclk_a && (ser_a != prev_ser_a)) || (lclk_a && sclk_a))
      viol_a <= viol_a + 1;
    prev_sclk_a <= sclk_a;
    prev_lclk_a <= lclk_a;
    prev_ser_a  <= ser_a;
  end

  // Chain / ladder model for instance B.
  logic        prev_sclk_b = 1'b0, prev_lclk_b = 1'b0;
  logic [15:0] chain_b = '0, ladder_b = '0;
  int          rise_cnt_b = 0, last_rise_b = -1, lclk_rise_b = -1;

  always @(negedge clk) begin
    if (sclk_b && !prev_sclk_b) begin
      rise_cnt_b  <= rise_cnt_b + 1;
      last_rise_b <= cyc;
      chain_b     <= {chain_b[14:0], ser_b};
    end
    if (lclk_b && !prev_lclk_b) begin
      ladder_b    <= chain_b;
      lclk_rise_b <= cyc;
    end
    prev_sclk_b <= sclk_b;
    prev_lclk_b <= lclk_b;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Waits (bounded) for a done pulse on the selected instance.
  task automatic wait_done(input bit sel_b, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (sel_b ? done_b : done_a) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({ser_a, sclk_a, lclk_a, done_a, busy_a, ready_a} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_pins_a got %b want 000001", {ser_a, sclk_a, lclk_a, done_a, busy_a, ready_a});
    end
    n_cmp++;
    if ({ser_b, sclk_b, lclk_b, done_b, busy_b, ready_b} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_pins_b got %b want 000001", {ser_b, sclk_b, lclk_b, done_b, busy_b, ready_b});
    end
    reset_ni = 1'b1;
    repeat (10) step();
    n_cmp++;
    if (rise_a.size() != 0) begin
      n_fail++;
      $display("FAIL idle_no_sclk got %0d edges want 0", rise_a.size());
    end
    n_cmp++;
    if ({busy_a, ready_a} !== 2'b01) begin
      n_fail++;
      $display("FAIL idle_busy_ready got %b want 01", {busy_a, ready_a});
    end
  endtask

  task automatic test_single();
    int base, lb, e0, t, bad;
    bit ok;
    base = rise_a.size();
    lb   = lclk_hi_a;
    data_a = 14'h2AAA; valid_a = 1'b1;
    step();
    valid_a = 1'b0; e0 = cyc;
    wait_done(1'b0, t, ok);
    n_cmp++;
    if (!ok || t != e0 + 66) begin
      n_fail++;
      $display("FAIL single_done_time got %0d want %0d (seen=%0d)", t - e0, 66, ok);
    end
    n_cmp++;
    if (rise_a.size() - base != 16) begin
      n_fail++;
      $display("FAIL single_edge_count got %0d want 16", rise_a.size() - base);
    end else begin
      bad = 0;
      for (int k = 1; k <= 16; k++) begin
        if (rise_a[base + k - 1] != e0 + (2 * k - 1) * 2) bad = k;
      end
      n_cmp++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL single_edge_time edge %0d got %0d want %0d", bad, rise_a[base + bad - 1] - e0, (2 * bad - 1) * 2);
      end
    end
    n_cmp++;
    if (lclk_rise_a != e0 + 64 || lclk_hi_a - lb != 2) begin
      n_fail++;
      $display("FAIL single_lclk got rise %0d width %0d want rise 64 width 2", lclk_rise_a - e0, lclk_hi_a - lb);
    end
    n_cmp++;
    if (ladder_a !== 16'h2AAA) begin
      n_fail++;
      $display("FAIL single_ladder got %h want 2aaa", ladder_a);
    end
    n_cmp++;
    if (ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready_at_done got %b want 1", ready_a);
    end
    step();
    n_cmp++;
    if (done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_width got %b want 0", done_a);
    end
    n_cmp++;
    if (viol_a != 0) begin
      n_fail++;
      $display("FAIL single_pin_order got %0d violations want 0", viol_a);
    end
  endtask

  task automatic test_back_to_back();
    int e0, e1, t;
    bit ok;
    data_a = 14'h0000; valid_a = 1'b1;
    step();
    e0 = cyc;
    data_a = 14'h3FFF;
    wait_done(1'b0, t, ok);
    n_cmp++;
    if (!ok || t != e0 + 66 || ladder_a !== 16'h0000) begin
      n_fail++;
      $display("FAIL b2b_first got done %0d ladder %h want done 66 ladder 0000", t - e0, ladder_a);
    end
    step();
    e1 = cyc;
    valid_a = 1'b0;
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept got busy %b want 1 at frame offset 67", busy_a);
    end
    wait_done(1'b0, t, ok);
    n_cmp++;
    if (!ok || t != e1 + 66 || ladder_a !== 16'h3FFF) begin
      n_fail++;
      $display("FAIL b2b_second got done %0d ladder %h want done 66 ladder 3fff", t - e1, ladder_a);
    end
  endtask

  task automatic test_busy_ignore();
    int dc, e0, t;
    bit ok;
    dc = done_cnt_a;
    data_a = 14'h1234; valid_a = 1'b1;
    step();
    e0 = cyc;
    for (int i = 0; i < 40; i++) begin
      data_a  = 14'(i * 517 + 1);
      valid_a = (i % 2 == 1);
      step();
    end
    valid_a = 1'b0;
    wait_done(1'b0, t, ok);
    repeat (20) step();
    n_cmp++;
    if (!ok || t != e0 + 66) begin
      n_fail++;
      $display("FAIL busy_done_time got %0d want 66", t - e0);
    end
    n_cmp++;
    if (ladder_a !== 16'h1234) begin
      n_fail++;
      $display("FAIL busy_ladder got %h want 1234", ladder_a);
    end
    n_cmp++;
    if (done_cnt_a - dc != 1) begin
      n_fail++;
      $display("FAIL busy_done_count got %0d want 1", done_cnt_a - dc);
    end
  endtask

  task automatic test_reset_midframe();
    int base, lc, e0, t, waited;
    bit ok;
    base = rise_a.size();
    lc   = lclk_cnt_a;
    data_a = 14'h0F0F; valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    waited = 0;
    while (rise_a.size() - base < 5 && waited < 100) begin
      step();
      waited++;
    end
    n_cmp++;
    if (rise_a.size() - base < 5) begin
      n_fail++;
      $display("FAIL midreset_reach_edge5 got %0d edges want 5", rise_a.size() - base);
    end
    reset_ni = 1'b0;
    #1;
    n_cmp++;
    if ({ser_a, sclk_a, lclk_a, done_a, busy_a, ready_a} !== 6'b000001) begin
      n_fail++;
      $display("FAIL midreset_pins got %b want 000001", {ser_a, sclk_a, lclk_a, done_a, busy_a, ready_a});
    end
    repeat (3) step();
    reset_ni = 1'b1;
    repeat (5) step();
    n_cmp++;
    if (lclk_cnt_a != lc || ladder_a !== 16'h1234) begin
      n_fail++;
      $display("FAIL midreset_ladder got %h lclk %0d want 1234 lclk 0", ladder_a, lclk_cnt_a - lc);
    end
    data_a = 14'h0F0F; valid_a = 1'b1;
    step();
    valid_a = 1'b0; e0 = cyc;
    wait_done(1'b0, t, ok);
    n_cmp++;
    if (!ok || t != e0 + 66 || ladder_a !== 16'h0F0F) begin
      n_fail++;
      $display("FAIL midreset_reload got done %0d ladder %h want 66 0f0f", t - e0, ladder_a);
    end
  endtask

  task automatic test_clkdiv1();
    int rb, e0, t;
    bit ok;
    rb = rise_cnt_b;
    data_b = 14'h0001; valid_b = 1'b1;
    step();
    valid_b = 1'b0; e0 = cyc;
    wait_done(1'b1, t, ok);
    n_cmp++;
    if (!ok || t != e0 + 33) begin
      n_fail++;
      $display("FAIL div1_done_time got %0d want 33", t - e0);
    end
    n_cmp++;
    if (rise_cnt_b - rb != 16 || last_rise_b != e0 + 31) begin
      n_fail++;
      $display("FAIL div1_sclk got %0d edges last %0d want 16 last 31", rise_cnt_b - rb, last_rise_b - e0);
    end
    n_cmp++;
    if (lclk_rise_b != e0 + 32) begin
      n_fail++;
      $display("FAIL div1_lclk got %0d want 32", lclk_rise_b - e0);
    end
    n_cmp++;
    if (ladder_b !== 16'h0001) begin
      n_fail++;
      $display("FAIL div1_ladder got %h want 0001", ladder_b);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midframe();
    test_clkdiv1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
